// File: rtl/ysyx_22041071_rd_refill.sv
// ysyx_22041071_rd_refill: arbitrates ICache/DCache line refills onto a single AXI read burst
module ysyx_22041071_rd_refill #(
  parameter int BEATS  = 4,
  parameter int LINE_W = 64*BEATS
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              ic_req_valid,
  input  logic [63:0]       ic_req_addr,
  output logic              ic_req_ready,
  input  logic              dc_req_valid,
  input  logic [63:0]       dc_req_addr,
  output logic              dc_req_ready,
  output logic              ic_resp_valid,
  output logic              dc_resp_valid,
  output logic [LINE_W-1:0] resp_line,
  output logic              resp_err,
  output logic              rd_ar_valid,
  input  logic              rd_ar_ready,
  output logic [3:0]        rd_id,
  output logic [63:0]       rd_addr,
  output logic [7:0]        rd_len,
  output logic [1:0]        rd_size,
  input  logic              rd_r_valid,
  input  logic [63:0]       rd_r_data,
  input  logic [1:0]        rd_r_resp
);
  localparam int CW = BEATS > 1 ? $clog2(BEATS) : 1;
  localparam logic [CW-1:0] LAST = CW'(BEATS-1);
  localparam logic [63:0] MASK = ~(64'(BEATS*8) - 64'd1);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;
  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic          r_last_dc;
  logic          w_idle, w_ic_gnt, w_dc_gnt;
  // reset_n gates the grant so req_ready stays low while reset is asserted
  assign w_idle       = reset_n && r_state == IDLE;
  assign w_dc_gnt     = w_idle && dc_req_valid && (!ic_req_valid || !r_last_dc);
  assign w_ic_gnt     = w_idle && ic_req_valid && (!dc_req_valid || r_last_dc);
  assign ic_req_ready = w_ic_gnt;
  assign dc_req_ready = w_dc_gnt;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_state       <= IDLE;
      r_cnt         <= '0;
      r_last_dc     <= 1'b0;
      resp_err      <= 1'b0;
      resp_line     <= '0;
      ic_resp_valid <= 1'b0;
      dc_resp_valid <= 1'b0;
      rd_ar_valid   <= 1'b0;
      rd_id         <= '0;
      rd_addr       <= '0;
      rd_len        <= '0;
      rd_size       <= '0;
    end else begin
      case (r_state)
        IDLE: if (w_ic_gnt || w_dc_gnt) begin
          r_last_dc   <= w_dc_gnt;
          rd_id       <= {3'b0, w_dc_gnt};
          rd_addr     <= (w_dc_gnt ? dc_req_addr : ic_req_addr) & MASK;
          rd_len      <= 8'(BEATS-1);
          rd_size     <= 2'b11;
          r_cnt       <= '0;
          resp_err    <= 1'b0;
          rd_ar_valid <= 1'b1;
          r_state     <= REQ;
        end
        REQ: if (rd_ar_ready) begin
          rd_ar_valid <= 1'b0;
          r_state     <= WAIT;
        end
        WAIT: if (rd_r_valid) begin
          resp_line[r_cnt*64 +: 64] <= rd_r_data;
          resp_err                  <= resp_err | (|rd_r_resp);
          r_cnt                     <= r_cnt + 1'b1;
          if (r_cnt == LAST) begin
            ic_resp_valid <= !rd_id[0];
            dc_resp_valid <= rd_id[0];
            r_state       <= RESP;
          end
        end
        RESP: begin
          ic_resp_valid <= 1'b0;
          dc_resp_valid <= 1'b0;
          r_state       <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
endmodule
